// File: rtl/dmux4way16_reg_if.sv
// Bus bundle for the registered 1-to-4 word demultiplexer: one shared input
// stream plus four independent output channels, each with a valid/ready pair.
interface dmux4way16_reg_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] out_cnt;

  // Word source and consumers side.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_cnt
  );
endinterface

// File: rtl/dmux4way16_reg.sv
// Registered 1-to-4 demultiplexer: each accepted word lands in a one-entry
// register for its selected channel; per-channel wrap-around delivery counters.
module dmux4way16_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dmux4way16_reg_if.slave  bus
);
  localparam int NCH = 4;

  logic [NCH-1:0][WIDTH-1:0] data_q, data_d;
  logic [NCH-1:0]            valid_q, valid_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic           in_ready;
  logic           acc;
  logic [NCH-1:0] dlv;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and an offered word must be held
  // by its source until it transfers. in_ready looks only at the selected slot.
  assign in_ready = rst_n && (!valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign acc      = bus.in_valid && in_ready;
  assign dlv      = valid_q & bus.out_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < NCH; k++) begin
      // A new word wins over delivery, so a draining slot refills with no bubble.
      if (acc && (bus.in_sel == 2'(k))) begin
        data_d[k]  = bus.in_data;
        valid_d[k] = 1'b1;
      end else if (dlv[k]) begin
        valid_d[k] = 1'b0;
      end
      if (dlv[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_cnt   = cnt_q;
endmodule

// File: tb/tb_dmux4way16_reg.sv
// Bench for dmux4way16_reg: directed scenarios plus random traffic, checked by
// a monitor against a queue of accepted words and per-channel delivery counts.
module tb_dmux4way16_reg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;

  dmux4way16_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  dmux4way16_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry = {channel, word}; words for one channel stay in acceptance order.
  logic [WIDTH+1:0] exp_q[$];
  logic [CNT_W-1:0] mcnt[4];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int find_ch(input int k);
    foreach (exp_q[i]) begin
      if (exp_q[i][WIDTH+1:WIDTH] == 2'(k)) return i;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  logic [3:0] mon_has;
  int         mon_idx;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      exp_q.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        mon_idx    = find_ch(k);
        mon_has[k] = (mon_idx >= 0);
        chk($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]), 32'(mon_has[k]));
        chk($sformatf("out_cnt%0d", k), 32'(bus.out_cnt[k*CNT_W +: CNT_W]), 32'(mcnt[k]));
        if (mon_has[k])
          chk($sformatf("out_data%0d", k), 32'(bus.out_data[k*WIDTH +: WIDTH]),
              32'(exp_q[mon_idx][WIDTH-1:0]));
      end
      chk("in_ready", 32'(bus.in_ready),
          32'(!mon_has[bus.in_sel] || bus.out_ready[bus.in_sel]));
      for (int k = 0; k < 4; k++) begin
        if (mon_has[k] && bus.out_ready[k]) begin
          mon_idx = find_ch(k);
          exp_q.delete(mon_idx);
          mcnt[k] = mcnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one word and holds it until accepted; reports cycles spent waiting.
  task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d, output int waited);
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      #1;
      if (bus.in_ready) begin
        exp_q.push_back({sel, d});
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got no in_ready expected in_ready=1 sel=%0d", sel);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          w;
  int          wsum;
  logic [CNT_W-1:0] c0_before;
  logic        pending;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd2;
    bus.in_data   = 16'hABCD;
    bus.out_ready = 4'b0000;

    // Reset with a word offered.
    idle(2);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_cnt", bus.out_cnt, 32'd0);
    chk("rst_in_ready_held", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    idle(1);

    // Routing to each channel.
    bus.out_ready = 4'b1111;
    send(2'd0, 16'h0001, w);
    send(2'd1, 16'h0002, w);
    send(2'd2, 16'h0003, w);
    send(2'd3, 16'h0004, w);
    idle(2);
    chk("route_cnts", bus.out_cnt, {4{8'd1}});

    // Backpressure on channel 1.
    bus.out_ready = 4'b1101;
    send(2'd1, 16'h1111, w);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd1;
    bus.in_data  = 16'h2222;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_data", 32'(bus.out_data[WIDTH +: WIDTH]), 32'h1111);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    send(2'd3, 16'h3333, w);
    chk("bp_other_ch_wait", w, 0);
    bus.out_ready = 4'b1111;
    send(2'd1, 16'h2222, w);
    chk("bp_release_same_cycle", w, 0);
    chk("bp_new_word", 32'(bus.out_data[WIDTH +: WIDTH]), 32'h2222);
    idle(2);

    // Back-to-back on channel 0.
    c0_before = bus.out_cnt[0 +: CNT_W];
    wsum      = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'd0, 16'h0010 + 16'(i), w);
      wsum += w;
    end
    idle(2);
    chk("b2b_no_stall", wsum, 0);
    chk("b2b_cnt_delta", 32'(bus.out_cnt[0 +: CNT_W] - c0_before), 32'd8);

    // Random traffic with random consumer readiness.
    pending = 1'b0;
    repeat (300) begin
      bus.out_ready = 4'($urandom);
      if (!pending && $urandom_range(0, 3) != 0) begin
        bus.in_sel  = 2'($urandom_range(0, 3));
        bus.in_data = 16'($urandom);
        pending     = 1'b1;
      end
      bus.in_valid = pending;
      @(negedge clk);
      #1;
      if (pending && bus.in_ready) begin
        exp_q.push_back({bus.in_sel, bus.in_data});
        pending = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b1111;
    idle(3);

    // Reset while channel 3 holds an undelivered word.
    bus.out_ready = 4'b0111;
    send(2'd3, 16'hBEEF, w);
    idle(2);
    chk("mid_valid3_held", 32'(bus.out_valid[3]), 32'd1);
    bus.out_ready = 4'b1111;
    rst_n         = 1'b0;
    idle(1);
    rst_n = 1'b1;
    #1;
    chk("mid_valid3_cleared", 32'(bus.out_valid[3]), 32'd0);
    chk("mid_cnt3_cleared", 32'(bus.out_cnt[3*CNT_W +: CNT_W]), 32'd0);
    idle(1);

    // Counter wrap on channel 2.
    for (int i = 0; i < 255; i++) send(2'd2, 16'($urandom), w);
    idle(1);
    chk("wrap_cnt_255", 32'(bus.out_cnt[2*CNT_W +: CNT_W]), 32'd255);
    send(2'd2, 16'($urandom), w);
    idle(1);
    chk("wrap_cnt_0", 32'(bus.out_cnt[2*CNT_W +: CNT_W]), 32'd0);

    idle(3);
    chk("drain_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmux4way16_reg.md
# dmux4way16_reg

Registered 1-to-4 demultiplexer for 16-bit words. It is the receiving-side counterpart of the 16-bit word multiplexers. One input stream carries a 2-bit channel select, and each accepted word is routed into a one-entry output register for that channel. Input and outputs use valid/ready handshakes, and each channel keeps a wrap-around count of delivered words. It sits between a shared word source and four independent consumers.

## Interface
Parameters:
- WIDTH, 16, data word width
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- in_data  in  WIDTH  word to route
- in_sel  in  2  destination channel 0..3
- in_valid  in  1  in_data/in_sel valid this cycle
- in_ready  out  1  block accepts the input word this cycle
- out_data  out  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- out_valid  out  4  channel k register holds an undelivered word
- out_ready  in  4  consumer k takes the word this cycle
- out_cnt  out  4*CNT_W  channel k delivered-word count at bits [k*CNT_W +: CNT_W]

## Operation
- Per channel k, the block holds three registers: data_k (WIDTH), valid_k (1), cnt_k (CNT_W).
- Input accept: acc = in_valid && in_ready.
- in_ready = rst_n && (!valid[in_sel] || out_ready[in_sel]).
  - in_ready is combinational on in_sel, valid and out_ready.
  - It depends on the selected channel only.
- Output handshake: dlv_k = valid_k && out_ready[k].
- Channel k update, in priority order:
  - acc with in_sel==k: data_k <= in_data, valid_k <= 1. If the slot was delivering this same cycle, the new word replaces it with no bubble.
  - else if dlv_k: valid_k <= 0. data_k holds its last value.
  - else: hold.
- Counter: on dlv_k, cnt_k <= cnt_k + 1, modulo 2^CNT_W (255 -> 0 at the default width). There is no saturation and no overflow flag.
- Channels are fully independent. A stalled channel, with valid_k=1 and out_ready[k]=0, blocks only inputs selecting k. Other selects still flow.
- The block does not reorder data and does not drop words. A word offered while in_ready=0 is not consumed; the source must hold it.
- in_sel and in_data are ignored when in_valid=0.

## Timing
- Reset: while rst_n=0 at a rising edge, all data_k <= 0, valid_k <= 0 and cnt_k <= 0.
  - in_ready is 0 throughout reset.
  - Reset mid-transfer discards any held word, with no delivery and no count increment.
- First cycle after reset release: in_ready=1 for any in_sel, out_valid=4'b0000.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N. It is visible in the cycle following acceptance and deliverable in that cycle.
- Throughput: one word per cycle. This holds per channel as long as out_ready[k]=1, and across channels with no constraint.
- Simultaneous events on one channel:
  - Delivery plus new accept: valid_k stays 1, data_k takes the new word, cnt_k increments once.
  - Delivery only: valid_k falls on the next edge.
- out_data for an invalid channel is don't-care for consumers. The design still holds the last value, or 0 after reset.
- Counter wrap: a delivery at cnt_k = 2^CNT_W-1 yields 0 on the next edge.

## Test plan
- Reset: drive rst_n=0 with in_valid=1, in_sel=2, in_data=16'hABCD for 2 edges. Required: out_valid=0, all out_cnt=0, in_ready=0. After release, in_ready=1.
- Routing: with out_ready=4'b1111, send 16'h0001, 16'h0002, 16'h0003, 16'h0004 to sel 0, 1, 2, 3 on consecutive cycles. Required: each appears on its channel exactly one cycle after acceptance, and each out_cnt reaches 1.
- Backpressure:
  - Setup: out_ready[1]=0. Send 16'h1111 to sel 1, then offer 16'h2222 to sel 1.
  - Required while stalled: in_ready=0 and out_data ch1 stays 16'h1111.
  - Required meanwhile: 16'h3333 to sel 3 is accepted.
  - Release: raise out_ready[1]. Required: 16'h2222 is accepted that same cycle, and ch1 shows 16'h2222 on the next cycle.
- Back-to-back on one channel: with out_ready[0]=1, stream 16'h0010..16'h0017 to sel 0 every cycle. Required: in_ready stays 1, all 8 words are delivered in order, and cnt_0=8.
- Wrap: deliver 256 words on channel 2. Required: cnt_2 reads 255 after 255 deliveries and 0 after the 256th.
- Reset mid-operation: hold valid_3=1 with out_ready[3]=0, then pulse rst_n=0 for one edge. Required: out_valid[3]=0, cnt_3=0, and no delivery is counted.
